// File: rtl/tdc_frame_ctrl.sv
`default_nettype none
// ============================================================================
// tdc_frame_ctrl : fires TDC shots on a fixed period, drains each result burst
//                  and reports the strongest hit of every frame.
// Revision       : 1.0
// ============================================================================
module tdc_frame_ctrl #(
  parameter int PER_W  = 16,
  parameter int SHOT_W = 8,
  parameter int TMO    = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_en,
  input  logic [PER_W-1:0]  cfg_period,
  input  logic [SHOT_W-1:0] cfg_shots,
  output logic              TDC_start,
  input  logic              TDC_INT,
  input  logic [9:0]        TDC_Odata,
  input  logic [4:0]        TDC_Oint,
  input  logic [1:0]        TDC_Onum,
  input  logic              TDC_Olast,
  input  logic              TDC_Ovalid,
  output logic              TDC_Oready,
  output logic [9:0]        frm_tof,
  output logic [4:0]        frm_int,
  output logic [SHOT_W+1:0] frm_hits,
  output logic              frm_valid,
  input  logic              frm_ready,
  output logic              busy,
  output logic              err_tmo,
  output logic              err_ovr
);

  localparam int TMO_W = $clog2(TMO + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FIRE, S_WAIT, S_DRAIN, S_GAP, S_REPORT
  } state_t;

  state_t              state, state_nx;
  logic                armed;
  logic [PER_W-1:0]    per_lat, per_cnt;
  logic [SHOT_W-1:0]   shots_lat, shot_cnt;
  logic [TMO_W-1:0]    tmo_cnt;
  logic [1:0]          beat_num, beat_cnt;
  logic                int_s1, int_s2, int_s3;
  logic [9:0]          best_tof;
  logic [4:0]          best_int;
  logic [SHOT_W+1:0]   hits;
  logic                tmo_flag, ovr_flag;

  logic                int_rise, beat, tmo_hit, shot_final, ack;
  logic [1:0]          beat_target;
  logic                frame_start, accum, tmo_set, ovr_set, shot_adv;

  assign int_rise    = int_s2 & ~int_s3;
  assign beat        = TDC_Ovalid & TDC_Oready;
  assign tmo_hit     = (tmo_cnt == TMO_W'(TMO - 1));
  assign shot_final  = (({1'b0, shot_cnt} + 1'b1) == {1'b0, shots_lat});
  assign ack         = (state == S_REPORT) && frm_ready;
  // Onum is only trusted on the first beat; later beats use the latched count
  assign beat_target = (beat_cnt == 2'd0) ? TDC_Onum : beat_num;

  always_comb begin
    state_nx    = state;
    frame_start = 1'b0;
    accum       = 1'b0;
    tmo_set     = 1'b0;
    ovr_set     = 1'b0;
    shot_adv    = 1'b0;
    case (state)
      S_IDLE: begin
        if (cfg_en && armed) begin
          state_nx    = S_FIRE;
          frame_start = 1'b1;
        end
      end
      S_FIRE: state_nx = S_WAIT;
      S_WAIT: begin
        if (int_rise) begin
          state_nx = S_DRAIN;
        end else if (tmo_hit) begin
          state_nx = S_GAP;
          tmo_set  = 1'b1;
        end
      end
      S_DRAIN: begin
        if (beat) begin
          if (beat_cnt == 2'd0 && TDC_Onum == 2'd0) begin
            state_nx = S_GAP;
          end else begin
            accum = 1'b1;
            if (TDC_Olast || ((beat_cnt + 2'd1) == beat_target))
              state_nx = S_GAP;
          end
        end else if (tmo_hit) begin
          state_nx = S_GAP;
          tmo_set  = 1'b1;
        end
      end
      S_GAP: begin
        // Leaving at count 1 lands the next FIRE exactly on the period boundary;
        // arriving here at 0 means the shot overran its slot.
        if (per_cnt <= PER_W'(1)) begin
          shot_adv = 1'b1;
          ovr_set  = (per_cnt == '0);
          state_nx = (shot_final || !cfg_en) ? S_REPORT : S_FIRE;
        end
      end
      S_REPORT: begin
        if (frm_ready) begin
          state_nx    = cfg_en ? S_FIRE : S_IDLE;
          frame_start = cfg_en;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      armed     <= 1'b0;
      per_lat   <= '0;
      per_cnt   <= '0;
      shots_lat <= '0;
      shot_cnt  <= '0;
      tmo_cnt   <= '0;
      beat_num  <= '0;
      beat_cnt  <= '0;
      int_s1    <= 1'b0;
      int_s2    <= 1'b0;
      int_s3    <= 1'b0;
      best_tof  <= '0;
      best_int  <= '0;
      hits      <= '0;
      tmo_flag  <= 1'b0;
      ovr_flag  <= 1'b0;
    end else begin
      state  <= state_nx;
      armed  <= 1'b1;
      int_s1 <= TDC_INT;
      int_s2 <= int_s1;
      int_s3 <= int_s2;

      if (state == S_FIRE)
        per_cnt <= per_lat - 1'b1;
      else if (per_cnt != '0)
        per_cnt <= per_cnt - 1'b1;

      if (state_nx != state)
        tmo_cnt <= '0;
      else if (state == S_WAIT || state == S_DRAIN)
        tmo_cnt <= tmo_cnt + 1'b1;

      if (state != S_DRAIN) begin
        beat_cnt <= '0;
      end else if (beat) begin
        if (beat_cnt == 2'd0)
          beat_num <= TDC_Onum;
        beat_cnt <= beat_cnt + 2'd1;
      end

      if (frame_start) begin
        per_lat   <= (cfg_period < PER_W'(8)) ? PER_W'(8) : cfg_period;
        shots_lat <= (cfg_shots == '0) ? SHOT_W'(1) : cfg_shots;
        shot_cnt  <= '0;
        tmo_flag  <= 1'b0;
        ovr_flag  <= 1'b0;
      end else begin
        if (tmo_set)  tmo_flag <= 1'b1;
        if (ovr_set)  ovr_flag <= 1'b1;
        if (shot_adv) shot_cnt <= shot_cnt + 1'b1;
      end

      if (frame_start || ack) begin
        hits     <= '0;
        best_tof <= '0;
        best_int <= '0;
      end else if (accum) begin
        if (hits != '1)
          hits <= hits + 1'b1;
        if (TDC_Oint > best_int) begin
          best_int <= TDC_Oint;
          best_tof <= TDC_Odata;
        end
      end
    end
  end

  assign TDC_start  = (state == S_FIRE);
  assign TDC_Oready = (state == S_DRAIN);
  assign frm_valid  = (state == S_REPORT);
  assign busy       = (state != S_IDLE);
  assign frm_tof    = best_tof;
  assign frm_int    = best_int;
  assign frm_hits   = hits;
  assign err_tmo    = tmo_flag;
  assign err_ovr    = ovr_flag;

endmodule
`default_nettype wire
